// File: rtl/des_frame_parser_pkg.sv
// Shared types and defaults for the frame parser.
// Optional per-frame statistics are enabled with DES_FRAME_STATS_EN.
package des_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LEN,
      ST_PAYLOAD,
      ST_CHK
   } parse_state_t;

   typedef enum logic [1:0] {
      ERR_OK,
      ERR_BAD_LEN,
      ERR_BAD_CHK
   } frame_err_t;

   localparam logic [7:0] DEF_SOF_BYTE = 8'hA5;
   localparam int         DEF_MAX_LEN  = 64;

endpackage

// File: rtl/des_frame_parser_if.sv
// FIFO read side plus payload valid/ready stream of the frame parser.
// master = parser, slave = FIFO and sink environment.
interface des_frame_parser_if;

   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_rd_en;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic       m_last;

   modport master (
      input  fifo_empty, fifo_data, m_ready,
      output fifo_rd_en, m_valid, m_data, m_last
   );

   modport slave (
      output fifo_empty, fifo_data, m_ready,
      input  fifo_rd_en, m_valid, m_data, m_last
   );

endinterface

// File: rtl/des_frame_parser_outreg.sv
// One-entry valid/ready output stage; data and last load together.
// A load in the same cycle as a drain keeps the stage full.
module des_frame_outreg #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] d_data,
   input  logic          d_last,
   input  logic          m_ready,
   output logic          m_valid,
   output logic [DW-1:0] m_data,
   output logic          m_last
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
      end else if (load) begin
         m_valid <= 1'b1;
         m_data  <= d_data;
         m_last  <= d_last;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/des_frame_parser.sv
// SOF hunter and length/payload/checksum parser on the FIFO read side.
// DES_FRAME_STATS_EN adds saturating good/bad frame counters.
module des_frame_parser
   import des_frame_pkg::*;
#(
   parameter logic [7:0] SOF_BYTE = DEF_SOF_BYTE,
   parameter int         MAX_LEN  = DEF_MAX_LEN,
   parameter int         DW       = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   des_frame_parser_if.master  bus,
   output logic                frame_done,
   output logic                frame_err,
   output logic [1:0]          err_code
`ifdef DES_FRAME_STATS_EN
   ,
   output logic [15:0]         good_cnt,
   output logic [15:0]         bad_cnt
`endif
);

   localparam logic [DW-1:0] MAX_L = DW'(MAX_LEN);

   parse_state_t  state;
   frame_err_t    err_q;
   logic [DW-1:0] cnt;
   logic [DW-1:0] sum;
   logic [DW-1:0] byte_in;
   logic          pop;
   logic          load;

   assign byte_in = bus.fifo_data;

   // Stage full and stalled blocks pops only while forwarding payload.
   assign pop = rst_n && !bus.fifo_empty &&
                (state != ST_PAYLOAD || !bus.m_valid || bus.m_ready);

   assign bus.fifo_rd_en = pop;
   assign load           = pop && (state == ST_PAYLOAD);
   assign err_code       = err_q;

   des_frame_outreg #(
      .DW (DW)
   ) u_outreg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .d_data  (byte_in),
      .d_last  (cnt == DW'(1)),
      .m_ready (bus.m_ready),
      .m_valid (bus.m_valid),
      .m_data  (bus.m_data),
      .m_last  (bus.m_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         sum        <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         err_q      <= ERR_OK;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         if (pop) begin
            unique case (state)
               ST_IDLE: begin
                  if (byte_in == SOF_BYTE) begin
                     state <= ST_LEN;
                     sum   <= '0;
                  end
               end
               ST_LEN: begin
                  if (byte_in > MAX_L) begin
                     state      <= ST_IDLE;
                     frame_done <= 1'b1;
                     frame_err  <= 1'b1;
                     err_q      <= ERR_BAD_LEN;
                  end else if (byte_in == '0) begin
                     state <= ST_CHK;
                     sum   <= byte_in;
                  end else begin
                     state <= ST_PAYLOAD;
                     cnt   <= byte_in;
                     sum   <= byte_in;
                  end
               end
               ST_PAYLOAD: begin
                  sum <= sum + byte_in;
                  cnt <= cnt - DW'(1);
                  if (cnt == DW'(1)) state <= ST_CHK;
               end
               ST_CHK: begin
                  state      <= ST_IDLE;
                  frame_done <= 1'b1;
                  if (byte_in == sum) begin
                     err_q <= ERR_OK;
                  end else begin
                     err_q     <= ERR_BAD_CHK;
                     frame_err <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

`ifdef DES_FRAME_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         good_cnt <= '0;
         bad_cnt  <= '0;
      end else if (frame_done) begin
         if (frame_err) begin
            if (bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;
         end else begin
            if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_des_frame_parser.sv
// Scoreboard bench for des_frame_parser with a queue-backed FWFT FIFO.
// Build with DES_FRAME_STATS_EN to also check the frame counters.
module tb_des_frame_parser;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       frame_done;
   logic       frame_err;
   logic [1:0] err_code;
`ifdef DES_FRAME_STATS_EN
   logic [15:0] good_cnt;
   logic [15:0] bad_cnt;
`endif

   des_frame_parser_if ifc ();

   des_frame_parser dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (ifc.master),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .err_code   (err_code)
`ifdef DES_FRAME_STATS_EN
      ,
      .good_cnt   (good_cnt),
      .bad_cnt    (bad_cnt)
`endif
   );

   always #5 clk = ~clk;

   logic [7:0] fq[$];
   logic [8:0] exp_d[$];
   logic [2:0] exp_s[$];
   logic [7:0] pl[$];

   int  n_chk = 0;
   int  n_err = 0;
   int  n_acc = 0;
   bit  hold_empty = 1'b0;
   bit  rand_ready = 1'b0;
   bit  ready_lvl  = 1'b1;

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // FIFO/sink model: drive just after negedge, observe just before posedge
   always begin
      @(negedge clk);
      #1;
      ifc.m_ready    = rand_ready ? 1'($urandom_range(0, 1)) : ready_lvl;
      ifc.fifo_empty = hold_empty || (fq.size() == 0);
      ifc.fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
      #3;
      if (rst_n) begin
         if (ifc.fifo_empty)
            chk("rd_en_empty", 32'(ifc.fifo_rd_en), 0);
         if (ifc.fifo_rd_en && !ifc.fifo_empty)
            void'(fq.pop_front());
         if (ifc.m_valid && ifc.m_ready) begin
            n_acc++;
            if (exp_d.size() == 0)
               chk("m_extra", {ifc.m_last, ifc.m_data}, 32'h1ff);
            else
               chk("m_byte", {ifc.m_last, ifc.m_data}, exp_d.pop_front());
         end
         if (frame_done) begin
            if (exp_s.size() == 0)
               chk("done_extra", {frame_err, err_code}, 32'h7);
            else
               chk("status", {frame_err, err_code}, exp_s.pop_front());
         end else if (frame_err) begin
            chk("err_wo_done", 32'(frame_err), 0);
         end
      end
   end

   task automatic push_frame(input logic [7:0] len, input bit bad,
                             input logic [7:0] badc);
      logic [7:0] s;
      logic [7:0] c;
      fq.push_back(8'hA5);
      fq.push_back(len);
      if (len > 8'd64) begin
         exp_s.push_back(3'b101);
         return;
      end
      s = len;
      for (int i = 0; i < int'(len); i++) begin
         fq.push_back(pl[i]);
         s = s + pl[i];
         exp_d.push_back({i == int'(len) - 1, pl[i]});
      end
      c = bad ? badc : s;
      fq.push_back(c);
      exp_s.push_back((c == s) ? 3'b000 : 3'b110);
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 1000; i++) begin
         if (fq.size() == 0 && exp_d.size() == 0 && exp_s.size() == 0 &&
             !ifc.m_valid)
            break;
         @(negedge clk);
      end
      if (i == 1000) chk("drain_timeout", 32'(exp_d.size() + exp_s.size()), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_acc(input int target);
      for (int i = 0; i < 300 && n_acc < target; i++) @(negedge clk);
      if (n_acc < target) chk("acc_timeout", n_acc, target);
   endtask

   initial begin
      int base;
      rst_n = 1'b0;
      #1;
      chk("rst_rd_en", 32'(ifc.fifo_rd_en), 0);
      chk("rst_valid", 32'(ifc.m_valid), 0);
      chk("rst_data", 32'(ifc.m_data), 0);
      chk("rst_last", 32'(ifc.m_last), 0);
      chk("rst_done", {frame_done, frame_err, err_code}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
      push_frame(8'd3, 1'b0, 8'h00);
      drain();

      fq.push_back(8'h00); fq.push_back(8'hFF); fq.push_back(8'h5A);
      pl.delete(); pl.push_back(8'h7E);
      push_frame(8'd1, 1'b0, 8'h00);
      drain();

      pl.delete(); pl.push_back(8'h01); pl.push_back(8'h02);
      push_frame(8'd2, 1'b1, 8'h00);
      drain();
      chk("err_hold", 32'(err_code), 2);

      push_frame(8'h41, 1'b0, 8'h00);
      pl.delete(); pl.push_back(8'h55);
      push_frame(8'd1, 1'b0, 8'h00);
      drain();
      chk("ok_after_badlen", 32'(err_code), 0);

      // SOF inside payload and zero-length frame
      pl.delete(); pl.push_back(8'hA5); pl.push_back(8'hA5);
      push_frame(8'd2, 1'b0, 8'h00);
      pl.delete();
      push_frame(8'd0, 1'b0, 8'h00);
      drain();

      base = n_acc;
      pl.delete();
      for (int i = 0; i < 8; i++) pl.push_back(8'(8'h30 + i));
      push_frame(8'd8, 1'b0, 8'h00);
      wait_acc(base + 2);
      ready_lvl = 1'b0;
      repeat (5) @(negedge clk);
      chk("stall_hold", 32'(ifc.m_valid), 1);
      ready_lvl  = 1'b1;
      hold_empty = 1'b1;
      repeat (3) @(negedge clk);
      hold_empty = 1'b0;
      drain();

      rand_ready = 1'b1;
      for (int f = 0; f < 4; f++) begin
         int n;
         n = (f == 0) ? 64 : $urandom_range(1, 12);
         pl.delete();
         for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
         push_frame(8'(n), f == 2, 8'($urandom));
         fq.push_back(8'($urandom_range(0, 8'hA4)));
      end
      drain();
      rand_ready = 1'b0;

      base = n_acc;
      pl.delete();
      for (int i = 0; i < 6; i++) pl.push_back(8'(8'h60 + i));
      push_frame(8'd6, 1'b0, 8'h00);
      wait_acc(base + 2);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {ifc.m_valid, ifc.m_last, ifc.m_data}, 0);
      chk("mid_rst_ctl", {ifc.fifo_rd_en, frame_done, frame_err, err_code}, 0);
      fq.delete();
      exp_d.delete();
      exp_s.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pl.delete(); pl.push_back(8'h12); pl.push_back(8'h34);
      push_frame(8'd2, 1'b0, 8'h00);
      drain();
      chk("post_rst_code", 32'(err_code), 0);
`ifdef DES_FRAME_STATS_EN
      chk("good_cnt", 32'(good_cnt), 1);
      chk("bad_cnt", 32'(bad_cnt), 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
